// File: rtl/interrupt_sequencer_if.sv
// interrupt_sequencer_if: pipeline-facing bundle of the interrupt sequencer.
// master = sequencer side, slave = pipeline/memory side.
interface interrupt_sequencer_if;
    logic        int_req;
    logic        rti_in_ex;
    logic        branch_taken;
    logic [31:0] pc_next;
    logic [2:0]  flags_in;
    logic [15:0] pop_data;
    logic        stall_out;
    logic        flush_out;
    logic        mem_push;
    logic        mem_pop;
    logic [15:0] push_data;
    logic        pc_load;
    logic [31:0] pc_load_value;
    logic        flags_restore;
    logic [2:0]  flags_value;
    logic        int_ack;
    logic        busy;
    modport master (
        input  int_req, rti_in_ex, branch_taken, pc_next, flags_in, pop_data,
        output stall_out, flush_out, mem_push, mem_pop, push_data, pc_load,
               pc_load_value, flags_restore, flags_value, int_ack, busy
    );
    modport slave (
        output int_req, rti_in_ex, branch_taken, pc_next, flags_in, pop_data,
        input  stall_out, flush_out, mem_push, mem_pop, push_data, pc_load,
               pc_load_value, flags_restore, flags_value, int_ack, busy
    );
endinterface

// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer: sequences interrupt entry (drain, push PC/flags, vector) and RTI return.
// Define INT_SAVE_FLAGS_EN to also save and restore the flag register on the stack.
module interrupt_sequencer #(
    parameter logic [31:0] ISR_ADDR     = 32'h0000_0020,
    parameter int          DRAIN_CYCLES = 2
) (
    input logic                   clk,
    input logic                   reset,
    interrupt_sequencer_if.master bus
);
    localparam int CW = $clog2(DRAIN_CYCLES + 1);
    typedef enum logic [3:0] {
        IDLE, DRAIN, PUSH_HI, PUSH_LO, PUSH_FLG, VECTOR, POP_FLG, POP_LO, POP_HI, RESTORE
    } state_t;
`ifdef INT_SAVE_FLAGS_EN
    localparam state_t RTI_FIRST = POP_FLG;
    localparam state_t AFTER_LO  = PUSH_FLG;
`else
    localparam state_t RTI_FIRST = POP_LO;
    localparam state_t AFTER_LO  = VECTOR;
`endif
    state_t        state, state_n;
    logic          int_req_q, pending;
    logic [31:0]   pc_q;
    logic [CW-1:0] cnt;
    logic          enter_drain, drain_done;
`ifdef INT_SAVE_FLAGS_EN
    logic [2:0]    flags_q;
`endif
    // RTI outranks a pending interrupt; a resolving branch only blocks entry
    assign enter_drain = state == IDLE && !bus.rti_in_ex && pending && !bus.branch_taken;
    assign drain_done  = cnt == CW'(DRAIN_CYCLES - 1);
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else       state <= state_n;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:     state_n = bus.rti_in_ex ? RTI_FIRST : enter_drain ? DRAIN : IDLE;
            DRAIN:    state_n = drain_done ? PUSH_HI : DRAIN;
            PUSH_HI:  state_n = PUSH_LO;
            PUSH_LO:  state_n = AFTER_LO;
            PUSH_FLG: state_n = VECTOR;
            VECTOR:   state_n = IDLE;
            POP_FLG:  state_n = POP_LO;
            POP_LO:   state_n = POP_HI;
            POP_HI:   state_n = RESTORE;
            default:  state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            int_req_q <= 1'b0;
            pending   <= 1'b0;
            pc_q      <= '0;
            cnt       <= '0;
`ifdef INT_SAVE_FLAGS_EN
            flags_q   <= '0;
`endif
        end else begin
            int_req_q <= bus.int_req;
            pending   <= (bus.int_req && !int_req_q) || (pending && !enter_drain);
            cnt       <= state == DRAIN ? cnt + CW'(1) : '0;
            if (enter_drain) pc_q <= bus.pc_next;
            if (state == POP_HI) pc_q[15:0] <= bus.pop_data;
            if (state == RESTORE) pc_q[31:16] <= bus.pop_data;
`ifdef INT_SAVE_FLAGS_EN
            if (enter_drain) flags_q <= bus.flags_in;
            if (state == POP_LO) flags_q <= bus.pop_data[2:0];
`endif
        end
    always_comb begin
        bus.busy          = state != IDLE;
        bus.stall_out     = state != IDLE;
        bus.flush_out     = state == DRAIN || state == RTI_FIRST;
        bus.mem_push      = state inside {PUSH_HI, PUSH_LO, PUSH_FLG};
        bus.mem_pop       = state inside {POP_FLG, POP_LO, POP_HI};
        bus.pc_load       = state == VECTOR || state == RESTORE;
        bus.int_ack       = state == VECTOR;
        bus.pc_load_value = state == VECTOR ? ISR_ADDR :
                            state == RESTORE ? {bus.pop_data, pc_q[15:0]} : '0;
`ifdef INT_SAVE_FLAGS_EN
        bus.push_data     = state == PUSH_HI ? pc_q[31:16] : state == PUSH_LO ? pc_q[15:0] :
                            state == PUSH_FLG ? {13'b0, flags_q} : '0;
        bus.flags_restore = state == RESTORE;
        bus.flags_value   = state == RESTORE ? flags_q : '0;
`else
        bus.push_data     = state == PUSH_HI ? pc_q[31:16] : state == PUSH_LO ? pc_q[15:0] : '0;
        bus.flags_restore = 1'b0;
        bus.flags_value   = '0;
`endif
    end
endmodule

// File: tb/tb_interrupt_sequencer.sv
// tb_interrupt_sequencer: directed scoreboard bench for interrupt entry, RTI, priority,
// branch blocking and mid-sequence reset; expectations follow INT_SAVE_FLAGS_EN.
module tb_interrupt_sequencer;
    localparam logic [31:0] ISR = 32'h0000_0020;
    // control vector: {busy, stall, flush, push, pop, pc_load, int_ack, flags_restore}
    localparam logic [7:0] C_IDLE = 8'h00, C_DRAIN = 8'hE0, C_PUSH = 8'hD0, C_VEC = 8'hC6;
    localparam logic [7:0] C_POPF = 8'hE8, C_POP = 8'hC8;
`ifdef INT_SAVE_FLAGS_EN
    localparam logic [7:0] C_REST = 8'hC5;
`else
    localparam logic [7:0] C_REST = 8'hC4;
`endif
    logic clk = 1'b0, reset = 1'b0;
    int n_cmp = 0, n_fail = 0;
    logic [15:0] exp_push[$], stack[$];
    logic [36:0] exp_load[$];
    logic [15:0] pend_pop = 16'hdead;

    interrupt_sequencer_if bus();
    interrupt_sequencer dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    function automatic logic [7:0] ctl_now();
        return {bus.busy, bus.stall_out, bus.flush_out, bus.mem_push, bus.mem_pop,
                bus.pc_load, bus.int_ack, bus.flags_restore};
    endfunction

    function automatic logic [63:0] outs_now();
        return 64'({ctl_now(), bus.push_data, bus.pc_load_value, bus.flags_value});
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ctl(input string tag, input logic [7:0] exp);
        chk(tag, 64'(ctl_now()), 64'(exp));
    endtask

    // one clock: drive stack read data after the edge, then score outputs mid-cycle
    task automatic tick();
        @(posedge clk);
        #1;
        bus.pop_data = pend_pop;
        pend_pop = 16'hdead;
        @(negedge clk);
        if (bus.mem_push) begin
            chk("push_expected", 64'(exp_push.size() != 0), 64'd1);
            if (exp_push.size() != 0) chk("push_data", 64'(bus.push_data), 64'(exp_push.pop_front()));
            stack.push_back(bus.push_data);
        end
        if (bus.mem_pop) begin
            chk("pop_nonempty", 64'(stack.size() != 0), 64'd1);
            if (stack.size() != 0) pend_pop = stack.pop_back();
        end
        if (bus.pc_load) begin
            chk("load_expected", 64'(exp_load.size() != 0), 64'd1);
            if (exp_load.size() != 0)
                chk("pc_load", 64'({bus.int_ack, bus.flags_restore, bus.flags_value, bus.pc_load_value}),
                    64'(exp_load.pop_front()));
        end
    endtask

    // called at the IDLE cycle in which pending is visible and entry is allowed
    task automatic seq_entry(input logic [31:0] pc, input logic [2:0] fl, input string tag);
        exp_push.push_back(pc[31:16]);
        exp_push.push_back(pc[15:0]);
`ifdef INT_SAVE_FLAGS_EN
        exp_push.push_back({13'b0, fl});
`endif
        exp_load.push_back({1'b1, 1'b0, 3'b000, ISR});
        for (int i = 0; i < 2; i++) begin tick(); ctl({tag, "_drain"}, C_DRAIN); end
        tick(); ctl({tag, "_push_hi"}, C_PUSH);
        tick(); ctl({tag, "_push_lo"}, C_PUSH);
`ifdef INT_SAVE_FLAGS_EN
        tick(); ctl({tag, "_push_flg"}, C_PUSH);
`endif
        tick(); ctl({tag, "_vector"}, C_VEC);
        tick(); ctl({tag, "_idle"}, C_IDLE);
    endtask

    task automatic entry(input logic [31:0] pc, input logic [2:0] fl, input string tag);
        bus.pc_next = pc;
        bus.flags_in = fl;
        bus.int_req = 1'b1;
        tick(); bus.int_req = 1'b0; ctl({tag, "_pend"}, C_IDLE);
        seq_entry(pc, fl, tag);
    endtask

    task automatic rti(input logic [31:0] pc, input logic [2:0] fl, input string tag);
        bus.rti_in_ex = 1'b1;
`ifdef INT_SAVE_FLAGS_EN
        exp_load.push_back({1'b0, 1'b1, fl, pc});
        tick(); bus.rti_in_ex = 1'b0; ctl({tag, "_pop_flg"}, C_POPF);
        tick(); ctl({tag, "_pop_lo"}, C_POP);
`else
        exp_load.push_back({1'b0, 1'b0, 3'b000, pc});
        tick(); bus.rti_in_ex = 1'b0; ctl({tag, "_pop_lo"}, C_POPF);
`endif
        tick(); ctl({tag, "_pop_hi"}, C_POP);
        tick(); ctl({tag, "_restore"}, C_REST);
        tick(); ctl({tag, "_idle"}, C_IDLE);
    endtask

    initial begin
        bus.int_req = 1'b0;
        bus.rti_in_ex = 1'b0;
        bus.branch_taken = 1'b0;
        bus.pc_next = '0;
        bus.flags_in = '0;
        bus.pop_data = 16'hdead;
        #1 reset = 1'b1;
        #1 chk("reset_outputs", outs_now(), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        tick(); ctl("idle_after_reset", C_IDLE);

        entry(32'h0001_2345, 3'b101, "entry");
        rti(32'h0001_2345, 3'b101, "rti");

        // RTI and interrupt edge together: RTI first, entry follows one IDLE cycle later
        entry(32'h0BAD_F00D, 3'b011, "pre");
        bus.pc_next = 32'h0000_4444;
        bus.flags_in = 3'b110;
        bus.int_req = 1'b1;
        rti(32'h0BAD_F00D, 3'b011, "prio_rti");
        seq_entry(32'h0000_4444, 3'b110, "prio_int");
        for (int i = 0; i < 3; i++) begin tick(); ctl("held_no_retrigger", C_IDLE); end
        bus.int_req = 1'b0;
        rti(32'h0000_4444, 3'b110, "rti2");

        // branch holds off entry for three cycles; capture happens when it drops
        bus.int_req = 1'b1;
        bus.branch_taken = 1'b1;
        bus.pc_next = 32'h1111_1111;
        bus.flags_in = 3'b001;
        tick(); bus.int_req = 1'b0; ctl("br_hold1", C_IDLE); bus.pc_next = 32'h2222_2222;
        tick(); ctl("br_hold2", C_IDLE); bus.pc_next = 32'h3333_3333;
        tick(); ctl("br_hold3", C_IDLE);
        bus.branch_taken = 1'b0;
        bus.pc_next = 32'h0004_5678;
        bus.flags_in = 3'b100;
        seq_entry(32'h0004_5678, 3'b100, "br");
        rti(32'h0004_5678, 3'b100, "br_rti");

        // reset during PUSH_LO with a second edge pending
        bus.pc_next = 32'h5555_AAAA;
        bus.flags_in = 3'b111;
        exp_push.push_back(16'h5555);
        exp_push.push_back(16'hAAAA);
        bus.int_req = 1'b1;
        tick(); bus.int_req = 1'b0; ctl("rst_pend", C_IDLE);
        tick(); ctl("rst_drain1", C_DRAIN); bus.int_req = 1'b1;
        tick(); ctl("rst_drain2", C_DRAIN); bus.int_req = 1'b0;
        tick(); ctl("rst_push_hi", C_PUSH);
        tick(); ctl("rst_push_lo", C_PUSH);
        #1 reset = 1'b1;
        #1 chk("rst_async_outputs", outs_now(), 64'd0);
        exp_push.delete();
        exp_load.delete();
        stack.delete();
        pend_pop = 16'hdead;
        tick(); chk("rst_held_outputs", outs_now(), 64'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin tick(); ctl("rst_pending_lost", C_IDLE); end
        entry(32'h89AB_CDEF, 3'b010, "post_rst");
        rti(32'h89AB_CDEF, 3'b010, "post_rst_rti");

        chk("push_queue_drained", 64'(exp_push.size()), 64'd0);
        chk("load_queue_drained", 64'(exp_load.size()), 64'd0);
        chk("stack_balanced", 64'(stack.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
